// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int unsigned UART_DIV_MIN   = 4;
  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic logic [15:0] uart_clamp_div(input logic [15:0] div);
    return (div < 16'(UART_DIV_MIN)) ? 16'(UART_DIV_MIN) : div;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; level counter is one bit wider than the pointers so
// full and empty are distinguishable.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          push_i,
  input  logic [UART_DATA_BITS-1:0]     data_i,
  input  logic                          pop_i,
  output logic [UART_DATA_BITS-1:0]     head_o,
  output logic [$clog2(DEPTH):0]        level_o,
  output logic                          full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]             wr_ptr_q;
  logic [AW-1:0]             rd_ptr_q;
  logic [AW:0]               level_q;
  logic                      do_push;
  logic                      do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (level_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// 8N1 UART transmitter fed from a byte FIFO. Define UART_TX_PARITY_EN to
// insert an even-parity bit between the data bits and the stop bit.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DEFAULT_DIV = 106
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [15:0]                   cfg_div,
  input  logic                          cfg_div_we,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          ser_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  uart_state_e                       state_q;
  logic [15:0]                       div_q;
  logic [15:0]                       frame_div_q;
  logic [15:0]                       cnt_q;
  logic [2:0]                        bit_q;
  logic [UART_DATA_BITS-1:0]         shift_q;
  logic                              ser_q;
  logic                              busy_q;
  logic [UART_DATA_BITS-1:0]         head;
  logic [$clog2(FIFO_DEPTH):0]       level;
  logic                              full;
  logic                              bit_end;
  logic                              pop;
`ifdef UART_TX_PARITY_EN
  logic                              par_q;
`endif

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push_i (in_valid),
    .data_i (in_data),
    .pop_i  (pop),
    .head_o (head),
    .level_o(level),
    .full_o (full)
  );

  assign in_ready   = !full;
  assign fifo_level = level;
  assign ser_tx     = ser_q;
  assign tx_busy    = busy_q;
  assign bit_end    = (cnt_q == frame_div_q - 16'd1);
  // Pop both from IDLE and at the last stop cycle so frames run back to back.
  assign pop        = (level != '0) && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q <= 16'(DEFAULT_DIV);
    end else if (cfg_div_we) begin
      div_q <= uart_clamp_div(cfg_div);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      frame_div_q <= 16'(DEFAULT_DIV);
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      ser_q       <= 1'b1;
      busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else if (pop) begin
      state_q     <= START;
      frame_div_q <= div_q;
      cnt_q       <= '0;
      shift_q     <= head;
      ser_q       <= 1'b0;
      busy_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q       <= ^head;
`endif
    end else begin
      cnt_q <= bit_end ? '0 : cnt_q + 16'd1;
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          ser_q  <= 1'b1;
          busy_q <= 1'b0;
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            bit_q   <= '0;
            ser_q   <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              ser_q   <= par_q;
`else
              state_q <= STOP;
              ser_q   <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              ser_q   <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            ser_q   <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ser_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ser_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: frame-level reference model plus directed timing checks.
module tb_uart_tx_stream;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] cfg_div = '0;
  logic        cfg_div_we = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        ser_tx;
  logic        tx_busy;
  logic [4:0]  fifo_level;

  uart_tx_stream #(
    .FIFO_DEPTH (16),
    .DEFAULT_DIV(106)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cfg_div   (cfg_div),
    .cfg_div_we(cfg_div_we),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ser_tx    (ser_tx),
    .tx_busy   (tx_busy),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a bit vector started at an edge index with a
  // fixed divider; line value = frame bit number (t - start) / div.
  logic [7:0]  mq[$];
  int          m_div = 106;
  bit          m_act = 1'b0;
  int          m_t = 0;
  int          m_start = 0;
  int          m_fdiv = 106;
  int          m_nb = 10;
  logic [10:0] m_bits = '1;
  int          m_lvl0;
  int          m_idx;
  logic [7:0]  m_b;
  bit          e_ser = 1'b1;
  bit          e_busy = 1'b0;
  int          e_level = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      m_div   = 106;
      m_act   = 1'b0;
      m_t     = 0;
      e_ser   = 1'b1;
      e_busy  = 1'b0;
      e_level = 0;
    end else begin
      m_lvl0 = mq.size();
      m_t++;
      if (m_act && (m_t - m_start == m_nb * m_fdiv)) m_act = 1'b0;
      if (!m_act && m_lvl0 != 0) begin
        m_b     = mq.pop_front();
        m_act   = 1'b1;
        m_start = m_t;
        m_fdiv  = m_div;
`ifdef UART_TX_PARITY_EN
        m_bits  = {1'b1, ^m_b, m_b, 1'b0};
        m_nb    = 11;
`else
        m_bits  = {2'b11, m_b, 1'b0};
        m_nb    = 10;
`endif
      end
      if (in_valid && m_lvl0 != DEPTH) mq.push_back(in_data);
      if (cfg_div_we) m_div = (cfg_div < 16'd4) ? 4 : int'(cfg_div);
      if (m_act) begin
        m_idx  = (m_t - m_start) / m_fdiv;
        e_ser  = m_bits[m_idx];
        e_busy = 1'b1;
      end else begin
        e_ser  = 1'b1;
        e_busy = 1'b0;
      end
      e_level = mq.size();
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One clock: wait for the falling edge and compare all outputs to the model.
  task automatic step();
    @(negedge clk);
    cyc++;
    chk("ser_tx",     32'(ser_tx),     32'(e_ser));
    chk("tx_busy",    32'(tx_busy),    32'(e_busy));
    chk("fifo_level", 32'(fifo_level), 32'(e_level));
    chk("in_ready",   32'(in_ready),   32'(e_level != DEPTH));
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic push_byte(input logic [7:0] b, output int c_fire);
    bit fire;
    int g;
    in_valid = 1'b1;
    in_data  = b;
    g = 0;
    do begin
      fire = in_ready;
      step();
      g++;
    end while (!fire && g < 5000);
    chk("push_timeout", 32'(fire), 32'd1);
    in_valid = 1'b0;
    c_fire = cyc;
  endtask

  task automatic set_div(input int d);
    cfg_div    = 16'(d);
    cfg_div_we = 1'b1;
    step();
    cfg_div_we = 1'b0;
  endtask

  initial begin
    int c0;
    int c1;
    int g;
    int pv;
    bit fire;
    logic [9:0] pat;

    repeat (3) step();
    resetn = 1'b1;
    repeat (2) step();

    // Single 0x55 at the default divider: start, 1010_1010 LSB first, stop.
    pat = 10'b1010101010;
    push_byte(8'h55, c0);
    for (int i = 0; i < 10; i++) begin
      run_to(c0 + 1 + i * 106 + 53);
      chk("t2_bit", 32'(ser_tx), 32'(pat[i]));
    end
    run_to(c0 + 1060);
    chk("t2_busy_end", 32'(tx_busy), 32'd1);
    step();
    chk("t2_busy_low", 32'(tx_busy), 32'd0);
    repeat (5) step();

    // Back-to-back bytes: second start bit directly follows the first stop.
    push_byte(8'h48, c0);
    push_byte(8'h69, c1);
    run_to(c0 + 1060);
    chk("t3_stop_h", 32'(ser_tx), 32'd1);
    step();
    chk("t3_start_i", 32'(ser_tx), 32'd0);
    chk("t3_busy", 32'(tx_busy), 32'd1);
    run_to(c0 + 2130);

    // Fill: one byte on the line, sixteen queued, next one held off.
    push_byte(8'hC3, c0);
    for (int i = 0; i < 16; i++) push_byte(8'(i * 17 + 1), c1);
    in_valid = 1'b1;
    in_data  = 8'h7E;
    run_to(c0 + 1060);
    chk("t4_full_level", 32'(fifo_level), 32'd16);
    chk("t4_full_ready", 32'(in_ready), 32'd0);
    step();
    chk("t4_pop_ready", 32'(in_ready), 32'd1);
    chk("t4_pop_level", 32'(fifo_level), 32'd15);
    step();
    in_valid = 1'b0;
    chk("t4_refill_level", 32'(fifo_level), 32'd16);

    // Asynchronous reset in the middle of a frame.
    run_to(c0 + 1400);
    #2 resetn = 1'b0;
    #1;
    chk("t1_ser", 32'(ser_tx), 32'd1);
    chk("t1_busy", 32'(tx_busy), 32'd0);
    chk("t1_level", 32'(fifo_level), 32'd0);
    chk("t1_ready", 32'(in_ready), 32'd1);
    repeat (3) step();
    resetn = 1'b1;
    repeat (3) step();

    // Divider change mid-frame only affects the following frame; small values clamp.
    push_byte(8'hA5, c0);
    run_to(c0 + 500);
    cfg_div    = 16'd20;
    cfg_div_we = 1'b1;
    push_byte(8'h3D, c1);
    cfg_div_we = 1'b0;
    run_to(c0 + 1060);
    chk("t5_old_stop", 32'(ser_tx), 32'd1);
    step();
    chk("t5_new_start", 32'(ser_tx), 32'd0);
    run_to(c0 + 1080);
    chk("t5_start_end", 32'(ser_tx), 32'd0);
    step();
    chk("t5_bit0", 32'(ser_tx), 32'd1);
    run_to(c0 + 1260);
    chk("t5_busy_end", 32'(tx_busy), 32'd1);
    step();
    chk("t5_busy_low", 32'(tx_busy), 32'd0);
    set_div(2);
    push_byte(8'h00, c1);
    run_to(c1 + 36);
    chk("t5_clamp_bit7", 32'(ser_tx), 32'd0);
    step();
    chk("t5_clamp_stop", 32'(ser_tx), 32'd1);
    run_to(c1 + 40);
    chk("t5_clamp_busy", 32'(tx_busy), 32'd1);
    step();
    chk("t5_clamp_done", 32'(tx_busy), 32'd0);

`ifdef UART_TX_PARITY_EN
    set_div(8);
    push_byte(8'h07, c1);
    run_to(c1 + 76);
    chk("t6_par_07", 32'(ser_tx), 32'd1);
    run_to(c1 + 88);
    chk("t6_busy_end", 32'(tx_busy), 32'd1);
    step();
    chk("t6_busy_low", 32'(tx_busy), 32'd0);
    push_byte(8'h03, c1);
    run_to(c1 + 76);
    chk("t6_par_03", 32'(ser_tx), 32'd0);
    run_to(c1 + 90);
`endif

    // Randomised traffic with varying offered load and divider writes.
    set_div(6);
    pv = 20;
    for (int i = 0; i < 20000; i++) begin
      if (i % 2000 == 0) pv = (i / 2000 % 3 == 0) ? 5 : ((i / 2000 % 3 == 1) ? 20 : 60);
      fire = in_valid && in_ready;
      step();
      cfg_div_we = 1'b0;
      if ($urandom_range(0, 199) == 0) begin
        cfg_div_we = 1'b1;
        cfg_div    = 16'($urandom_range(0, 14));
      end
      if (fire || !in_valid) begin
        in_valid = ($urandom_range(0, 99) < pv);
        in_data  = 8'($urandom);
      end
    end
    in_valid   = 1'b0;
    cfg_div_we = 1'b0;
    g = 0;
    while ((m_act || mq.size() != 0) && g < 20000) begin
      step();
      g++;
    end
    step();
    chk("drain_busy", 32'(tx_busy), 32'd0);
    chk("drain_level", 32'(fifo_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
